// File: rtl/alu_pkg.sv
// Shared ALU/issue definitions: ALU operation codes, RV32I opcodes and the
// decoded-control bundle passed from the decoder to the issue stage.
package alu_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b1000;
    localparam logic [3:0] ALU_XOR = 4'b0100;
    localparam logic [3:0] ALU_SLL = 4'b0101;
    localparam logic [3:0] ALU_SRL = 4'b0111;
    localparam logic [3:0] ALU_SRA = 4'b1101;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    typedef enum logic [1:0] {
        A_RS1  = 2'd0,
        A_PC   = 2'd1,
        A_ZERO = 2'd2
    } a_sel_e;

    typedef struct packed {
        logic [3:0] alu_ctrl;
        a_sel_e     a_sel;
        logic       b_imm;
        logic [4:0] rd;
        logic       uses_rs1;
        logic       uses_rs2;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic       branch_ne;
        logic       jump;
        logic       illegal;
    } ctrl_t;

endpackage

// File: rtl/alu_issue_decode.sv
// Combinational RV32I decode: instruction word to ALU control, operand
// selects and immediate. Shift decode exists only with ALU_ISSUE_SHIFT_EN.
module alu_issue_decode
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    output ctrl_t           ctrl,
    output logic [XLEN-1:0] imm
);

    logic [6:0]         opcode;
    logic [2:0]         funct3;
    logic [6:0]         funct7;
    logic signed [31:0] imm32;
    logic               legal;
    ctrl_t              c;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];

    always_comb begin
        c        = '0;
        c.a_sel  = A_RS1;
        imm32    = '0;
        legal    = 1'b0;
        case (opcode)
            OP_R: begin
                c.uses_rs1  = 1'b1;
                c.uses_rs2  = 1'b1;
                c.reg_write = 1'b1;
                legal       = 1'b1;
                case ({funct7, funct3})
                    {7'h00, 3'b000}: c.alu_ctrl = ALU_ADD;
                    {7'h20, 3'b000}: c.alu_ctrl = ALU_SUB;
                    {7'h00, 3'b111}: c.alu_ctrl = ALU_AND;
                    {7'h00, 3'b110}: c.alu_ctrl = ALU_OR;
                    {7'h00, 3'b100}: c.alu_ctrl = ALU_XOR;
                    {7'h00, 3'b010}: c.alu_ctrl = ALU_SLT;
`ifdef ALU_ISSUE_SHIFT_EN
                    {7'h00, 3'b001}: c.alu_ctrl = ALU_SLL;
                    {7'h00, 3'b101}: c.alu_ctrl = ALU_SRL;
                    {7'h20, 3'b101}: c.alu_ctrl = ALU_SRA;
`endif
                    default:         legal      = 1'b0;
                endcase
            end
            OP_I: begin
                c.uses_rs1  = 1'b1;
                c.reg_write = 1'b1;
                c.b_imm     = 1'b1;
                imm32       = {{20{instr[31]}}, instr[31:20]};
                legal       = 1'b1;
                case (funct3)
                    3'b000:  c.alu_ctrl = ALU_ADD;
                    3'b111:  c.alu_ctrl = ALU_AND;
                    3'b110:  c.alu_ctrl = ALU_OR;
                    3'b100:  c.alu_ctrl = ALU_XOR;
                    3'b010:  c.alu_ctrl = ALU_SLT;
`ifdef ALU_ISSUE_SHIFT_EN
                    3'b001: begin
                        legal      = (funct7 == 7'h00);
                        c.alu_ctrl = ALU_SLL;
                        imm32      = {27'd0, instr[24:20]};
                    end
                    3'b101: begin
                        legal      = (funct7 == 7'h00) || (funct7 == 7'h20);
                        c.alu_ctrl = funct7[5] ? ALU_SRA : ALU_SRL;
                        imm32      = {27'd0, instr[24:20]};
                    end
`endif
                    default: legal      = 1'b0;
                endcase
            end
            OP_LOAD: begin
                legal       = (funct3 == 3'b010);
                c.alu_ctrl  = ALU_ADD;
                c.uses_rs1  = 1'b1;
                c.b_imm     = 1'b1;
                c.mem_read  = 1'b1;
                c.reg_write = 1'b1;
                imm32       = {{20{instr[31]}}, instr[31:20]};
            end
            OP_STORE: begin
                legal       = (funct3 == 3'b010);
                c.alu_ctrl  = ALU_ADD;
                c.uses_rs1  = 1'b1;
                c.uses_rs2  = 1'b1;
                c.b_imm     = 1'b1;
                c.mem_write = 1'b1;
                imm32       = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            end
            OP_BRANCH: begin
                legal       = (funct3[2:1] == 2'b00);
                c.alu_ctrl  = ALU_SUB;
                c.uses_rs1  = 1'b1;
                c.uses_rs2  = 1'b1;
                c.branch    = 1'b1;
                c.branch_ne = funct3[0];
            end
            OP_JAL: begin
                legal       = 1'b1;
                c.alu_ctrl  = ALU_ADD;
                c.a_sel     = A_PC;
                c.b_imm     = 1'b1;
                c.jump      = 1'b1;
                c.reg_write = 1'b1;
                imm32       = 32'sd4;
            end
            OP_LUI: begin
                legal       = 1'b1;
                c.alu_ctrl  = ALU_ADD;
                c.a_sel     = A_ZERO;
                c.b_imm     = 1'b1;
                c.reg_write = 1'b1;
                imm32       = {instr[31:12], 12'd0};
            end
            default: legal = 1'b0;
        endcase
        if (!legal) begin
            c         = '0;
            c.illegal = 1'b1;
        end
        if (c.reg_write) c.rd = instr[11:7];
        // Writes to x0 are architecturally discarded, so never claim one.
        if (c.rd == 5'd0) c.reg_write = 1'b0;
    end

    assign ctrl = c;
    assign imm  = XLEN'(imm32);

endmodule

// File: rtl/alu_issue.sv
// Decode/issue stage feeding the EX-stage ALU: handshake, load-use interlock,
// flush and the ID/EX register. Shift support is enabled by ALU_ISSUE_SHIFT_EN.
module alu_issue
    import alu_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int PC_W = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [PC_W-1:0] in_pc,
    output logic [4:0]      rs1_addr,
    output logic [4:0]      rs2_addr,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic            flush,
    output logic            ex_valid,
    input  logic            ex_ready,
    output logic [XLEN-1:0] ex_a,
    output logic [XLEN-1:0] ex_b,
    output logic [3:0]      ex_alu_ctrl,
    output logic [XLEN-1:0] ex_rs2_data,
    output logic [4:0]      ex_rd,
    output logic            ex_reg_write,
    output logic            ex_mem_read,
    output logic            ex_mem_write,
    output logic            ex_branch,
    output logic            ex_branch_ne,
    output logic            ex_jump,
    output logic [PC_W-1:0] ex_pc,
    output logic            illegal
);

    ctrl_t           dec;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] a_next;
    logic [XLEN-1:0] b_next;
    logic            hazard;
    logic            accept;

    alu_issue_decode #(.XLEN(XLEN)) u_decode (
        .instr (in_instr),
        .ctrl  (dec),
        .imm   (imm)
    );

    assign rs1_addr = in_instr[19:15];
    assign rs2_addr = in_instr[24:20];

    // Only sources the instruction really reads can create a load-use stall.
    assign hazard = ex_valid && ex_mem_read && (ex_rd != 5'd0) &&
                    ((dec.uses_rs1 && (rs1_addr == ex_rd)) ||
                     (dec.uses_rs2 && (rs2_addr == ex_rd)));
    assign in_ready = !hazard && (!ex_valid || ex_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        case (dec.a_sel)
            A_PC:    a_next = XLEN'(in_pc);
            A_ZERO:  a_next = '0;
            default: a_next = rs1_data;
        endcase
        b_next = dec.b_imm ? imm : rs2_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid     <= 1'b0;
            ex_a         <= '0;
            ex_b         <= '0;
            ex_alu_ctrl  <= '0;
            ex_rs2_data  <= '0;
            ex_rd        <= '0;
            ex_reg_write <= 1'b0;
            ex_mem_read  <= 1'b0;
            ex_mem_write <= 1'b0;
            ex_branch    <= 1'b0;
            ex_branch_ne <= 1'b0;
            ex_jump      <= 1'b0;
            ex_pc        <= '0;
            illegal      <= 1'b0;
        end else begin
            illegal <= 1'b0;
            if (flush) begin
                ex_valid <= 1'b0;
            end else if (accept) begin
                // Unsupported encodings leave as a bubble with cleared controls.
                ex_valid     <= !dec.illegal;
                illegal      <= dec.illegal;
                ex_a         <= a_next;
                ex_b         <= b_next;
                ex_alu_ctrl  <= dec.alu_ctrl;
                ex_rs2_data  <= rs2_data;
                ex_rd        <= dec.rd;
                ex_reg_write <= dec.reg_write;
                ex_mem_read  <= dec.mem_read;
                ex_mem_write <= dec.mem_write;
                ex_branch    <= dec.branch;
                ex_branch_ne <= dec.branch_ne;
                ex_jump      <= dec.jump;
                ex_pc        <= in_pc;
            end else if (!ex_valid || ex_ready) begin
                ex_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/alu_issue.md
# alu_issue

Decode/issue stage that drives the EX-stage ALU. Accepts one RV32I instruction per cycle from fetch, decodes it into the 4-bit ALU control code and operand selects, and reads the register file. Registers the result into an ID/EX pipeline register with valid/ready flow control, load-use interlock and flush. It is the producer side of the ALU's `a`/`b`/`alu_ctrl` interface.

## Interface
Parameters:
- `XLEN`, 32, datapath width.
- `PC_W`, 32, program-counter width.

Ports (reset is asynchronous, active-high):
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: fetch holds a valid instruction.
- `in_ready` out 1: stage accepts the instruction this cycle.
- `in_instr` in 32: instruction word.
- `in_pc` in PC_W: its PC.
- `rs1_addr`, `rs2_addr` out 5 each: combinational register-file read addresses, taken from `in_instr[19:15]` and `in_instr[24:20]`.
- `rs1_data`, `rs2_data` in XLEN: same-cycle register-file read data.
- `flush` in 1: kill the ID/EX contents and any instruction accepted this cycle.
- `ex_valid` out 1: ID/EX register holds a valid instruction.
- `ex_ready` in 1: EX consumes the register this cycle.
- `ex_a`, `ex_b` out XLEN: ALU operands.
- `ex_alu_ctrl` out 4: ALU operation code.
- `ex_rs2_data` out XLEN: store data.
- `ex_rd` out 5: destination register.
- `ex_reg_write`, `ex_mem_read`, `ex_mem_write`, `ex_branch`, `ex_branch_ne`, `ex_jump` out 1 each: control flags.
- `ex_pc` out PC_W: PC of the instruction in ID/EX.
- `illegal` out 1: one-cycle pulse when an unsupported instruction is accepted.

## Operation
- ALU codes: AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 1000, XOR 0100, SLL 0101, SRL 0111, SRA 1101.
- R-type (0110011): funct3/funct7 map to ADD, SUB, AND, OR, XOR, SLT, SLL, SRL, SRA. `a` = rs1, `b` = rs2.
- I-ALU (0010011): ADDI, ANDI, ORI, XORI, SLTI, SLLI, SRLI, SRAI. `b` = sign-extended imm[11:0]. For shifts, `b` = zero-extended shamt; funct7[5] selects SRA.
- LW (0000011, funct3 010): ADD, `b` = I-imm, `mem_read`, `reg_write`.
- SW (0100011, funct3 010): ADD, `b` = S-imm, `mem_write`.
- BEQ/BNE (1100011, funct3 000/001): SUB, `branch`; `branch_ne` is set for BNE.
- JAL (1101111): `a` = PC, `b` = 4, ADD, `jump`, `reg_write`.
- LUI (0110111): `a` = 0, `b` = U-imm, ADD, `reg_write`.
- Anything else, including SLTU/SLTIU: accepted, `illegal` pulses, and a bubble is issued (`ex_valid` = 0).
- `ex_reg_write` is forced to 0 when rd = x0.
- Load-use hazard: asserted when `ex_valid`, `ex_mem_read`, `ex_rd` ≠ 0, and `ex_rd` equals a source register actually used by `in_instr`. While asserted, `in_ready` = 0. If `ex_ready` is also high, the register loads a bubble.
- `in_ready` = !hazard && (!ex_valid || ex_ready).

## Timing
- Reset: every `ex_*` output is 0, `illegal` = 0, `in_ready` = 1.
- Latency: the instruction is accepted at edge N and appears on `ex_*` in cycle N+1.
- Back-to-back: throughput is 1 per cycle while `ex_ready` = 1 and there is no hazard.
- Stall: while `ex_valid` && !`ex_ready`, every `ex_*` output holds stable.
- `flush`: at the next edge `ex_valid` = 0. An instruction accepted in the same cycle is dropped and `illegal` is suppressed. `flush` overrides hazard and stall.
- `rst` asserted mid-stream clears state immediately, without waiting for the clock.
- `illegal` is registered and is high for exactly the cycle after the accepting edge.

## Configuration
- `ALU_ISSUE_SHIFT_EN` defined: SLL/SRL/SRA/SLLI/SRLI/SRAI are decoded as above.
- `ALU_ISSUE_SHIFT_EN` undefined: every shift encoding is treated as illegal (bubble plus `illegal` pulse), and the shift decode logic is absent.

## Structure
- Shared package `alu_pkg` contains:
  - the ALU code constants (`ALU_AND`…`ALU_SRA`);
  - the opcode constants (`OP_R`, `OP_I`, `OP_LOAD`, `OP_STORE`, `OP_BRANCH`, `OP_JAL`, `OP_LUI`);
  - a decoded-control struct typedef.
- Sub-module `alu_issue_decode`: purely combinational instruction-to-control and immediate generation. The top level holds the handshake, the hazard logic and the ID/EX register.

## Test plan
- Reset, then `add x3,x1,x2` (0x002081B3) with rs1=7, rs2=5, and `ex_ready`=1: next cycle `ex_a`=7, `ex_b`=5, `ex_alu_ctrl`=0010, `ex_rd`=3, `ex_reg_write`=1.
- `sub` (0x402081B3), then `srai x7,x1,3` (0x4030D393) back-to-back: consecutive cycles show 0110 then 1101 with `ex_b`=3. With the macro undefined, the second instruction instead gives `illegal`=1 and `ex_valid`=0.
- `lw x5,0(x1)` (0x0000A283) followed by `add x6,x5,x5` (0x00528333): `in_ready`=0 for one cycle and one bubble is issued; the add appears two cycles after the lw.
- `ex_ready`=0 for 3 cycles with `addi x1,x0,5` (0x00500093) in ID/EX: outputs hold `ex_b`=5, `in_ready`=0, and the next instruction is not lost.
- `flush` in the same cycle an instruction is accepted: the next cycle `ex_valid`=0 and `illegal`=0.
- Word 0x00000000 issued: `illegal` pulses for 1 cycle and `ex_valid`=0. Also `addi x0,x0,1`: `ex_reg_write`=0.
